// File: rtl/tensor_core_arbiter.sv
// Round-robin arbiter sharing one in-order tensor core among NUM_REQ issue requesters, plus a small ID FIFO.
// Latency: request->tc_in_valid_o and core result->rsp_valid_o are combinational; grant/lock/FIFO state updates next cycle.
// Backpressure: the grant is held while the core stalls, issue stops at MAX_INFLIGHT outstanding, rsp_ready_i stalls the core output.
`ifndef NUM_THREAD
`define NUM_THREAD 4
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif

// Generic in-order FIFO with occupancy count; caller guarantees no push when full and no pop when empty.
// Latency: a pushed entry becomes visible at the head on the next cycle.
// Backpressure: none internally; space freed by a pop is reported one cycle later through count.
module tca_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Storage needs no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap modulo depth; count tracks push/pop, unchanged when both happen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + ($clog2(DEPTH)+1)'(1);
      else if (pop && !push) count <= count - ($clog2(DEPTH)+1)'(1);
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module tensor_core_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int VL           = `NUM_THREAD,
  parameter int WORD_W       = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*VL*WORD_W-1:0]    req_a_i,
  input  logic [NUM_REQ*VL*WORD_W-1:0]    req_b_i,
  input  logic [NUM_REQ*VL*WORD_W-1:0]    req_c_i,
  input  logic [NUM_REQ*VL*3-1:0]         req_rm_i,
  input  logic [NUM_REQ*8-1:0]            req_reg_idxw_i,
  input  logic [NUM_REQ*`DEPTH_WARP-1:0]  req_warpid_i,
  output logic                            tc_in_valid_o,
  input  logic                            tc_in_ready_i,
  output logic [VL*WORD_W-1:0]            tc_a_o,
  output logic [VL*WORD_W-1:0]            tc_b_o,
  output logic [VL*WORD_W-1:0]            tc_c_o,
  output logic [VL*3-1:0]                 tc_rm_o,
  output logic [7:0]                      tc_reg_idxw_o,
  output logic [`DEPTH_WARP-1:0]          tc_warpid_o,
  input  logic                            tc_out_valid_i,
  output logic                            tc_out_ready_o,
  input  logic [VL*WORD_W-1:0]            tc_result_i,
  input  logic [VL*5-1:0]                 tc_fflags_i,
  input  logic [7:0]                      tc_reg_idxw_i,
  input  logic [`DEPTH_WARP-1:0]          tc_warpid_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  input  logic [NUM_REQ-1:0]              rsp_ready_i,
  output logic [VL*WORD_W-1:0]            rsp_result_o,
  output logic [VL*5-1:0]                 rsp_fflags_o,
  output logic [7:0]                      rsp_reg_idxw_o,
  output logic [`DEPTH_WARP-1:0]          rsp_warpid_o,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight_o,
  output logic                            err_o
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int OPW = VL * WORD_W;
  localparam int CW  = $clog2(MAX_INFLIGHT) + 1;
  localparam int DW  = `DEPTH_WARP;

  logic [IDW-1:0] rr_ptr;
  logic           lock_vld;
  logic [IDW-1:0] lock_id;
  logic           err;

  logic [IDW-1:0] g;
  logic [IDW-1:0] cand;
  logic           grant_exists;
  logic [IDW-1:0] head;
  logic [CW-1:0]  count;
  logic           not_full;
  logic           has_out;
  logic           issue_fire;
  logic           rsp_fire;

  // Grant: the held lock wins; otherwise first valid requester at or after rr_ptr.
  always_comb begin
    g            = lock_id;
    grant_exists = 1'b0;
    cand         = '0;
    if (lock_vld) begin
      grant_exists = req_valid_i[lock_id];
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = rr_ptr + IDW'(i);
        if (!grant_exists && req_valid_i[cand]) begin
          grant_exists = 1'b1;
          g            = cand;
        end
      end
    end
  end

  assign not_full      = (count < CW'(MAX_INFLIGHT));
  assign has_out       = (count != '0);
  // Gate with rst_n so nothing handshakes while reset is asserted.
  assign tc_in_valid_o = rst_n & grant_exists & not_full;
  assign issue_fire    = tc_in_valid_o & tc_in_ready_i;
  assign tc_out_ready_o = rsp_ready_i[head] & has_out;
  assign rsp_fire      = tc_out_valid_i & tc_out_ready_o;

  // One-hot ready to the granted requester and one-hot response valid to the FIFO head owner.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (tc_in_valid_o && tc_in_ready_i) req_ready_o[g] = 1'b1;
    if (tc_out_valid_i && has_out)      rsp_valid_o[head] = 1'b1;
  end

  assign tc_a_o        = req_a_i[int'(g)*OPW +: OPW];
  assign tc_b_o        = req_b_i[int'(g)*OPW +: OPW];
  assign tc_c_o        = req_c_i[int'(g)*OPW +: OPW];
  assign tc_rm_o       = req_rm_i[int'(g)*VL*3 +: VL*3];
  assign tc_reg_idxw_o = req_reg_idxw_i[int'(g)*8 +: 8];
  assign tc_warpid_o   = req_warpid_i[int'(g)*DW +: DW];

  assign rsp_result_o   = tc_result_i;
  assign rsp_fflags_o   = tc_fflags_i;
  assign rsp_reg_idxw_o = tc_reg_idxw_i;
  assign rsp_warpid_o   = tc_warpid_i;

  assign inflight_o = count;
  assign err_o      = err;

  // Round-robin pointer advances past each issued requester; a stalled offer locks the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_id  <= '0;
    end else if (issue_fire) begin
      rr_ptr   <= g + IDW'(1);
      lock_vld <= 1'b0;
    end else if (tc_in_valid_o) begin
      lock_vld <= 1'b1;
      lock_id  <= g;
    end
  end

  // Sticky error: result with nothing outstanding, or a locked requester dropping valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err | (tc_out_valid_i & ~has_out) | (lock_vld & ~req_valid_i[lock_id]);
  end

  tca_fifo #(.W(IDW), .DEPTH(MAX_INFLIGHT)) u_id_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (issue_fire),
    .push_dat (g),
    .pop      (rsp_fire),
    .head_dat (head),
    .count    (count)
  );
endmodule

// File: tb/tb_tensor_core_arbiter.sv
`ifndef NUM_THREAD
`define NUM_THREAD 4
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif

module tb_tensor_core_arbiter;
  localparam int NR  = 4;
  localparam int VL  = `NUM_THREAD;
  localparam int WW  = 32;
  localparam int MI  = 4;
  localparam int DW  = `DEPTH_WARP;
  localparam int OPW = VL * WW;
  localparam int CW  = $clog2(MI) + 1;

  logic clk;
  logic rst_n;
  logic [NR-1:0]        req_valid_i;
  logic [NR-1:0]        req_ready_o;
  logic [NR*OPW-1:0]    req_a_i, req_b_i, req_c_i;
  logic [NR*VL*3-1:0]   req_rm_i;
  logic [NR*8-1:0]      req_reg_idxw_i;
  logic [NR*DW-1:0]     req_warpid_i;
  logic                 tc_in_valid_o, tc_in_ready_i;
  logic [OPW-1:0]       tc_a_o, tc_b_o, tc_c_o;
  logic [VL*3-1:0]      tc_rm_o;
  logic [7:0]           tc_reg_idxw_o;
  logic [DW-1:0]        tc_warpid_o;
  logic                 tc_out_valid_i, tc_out_ready_o;
  logic [OPW-1:0]       tc_result_i;
  logic [VL*5-1:0]      tc_fflags_i;
  logic [7:0]           tc_reg_idxw_i;
  logic [DW-1:0]        tc_warpid_i;
  logic [NR-1:0]        rsp_valid_o, rsp_ready_i;
  logic [OPW-1:0]       rsp_result_o;
  logic [VL*5-1:0]      rsp_fflags_o;
  logic [7:0]           rsp_reg_idxw_o;
  logic [DW-1:0]        rsp_warpid_o;
  logic [CW-1:0]        inflight_o;
  logic                 err_o;

  int checks = 0;
  int errors = 0;

  tensor_core_arbiter #(.NUM_REQ(NR), .VL(VL), .WORD_W(WW), .MAX_INFLIGHT(MI)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_c_i(req_c_i),
    .req_rm_i(req_rm_i), .req_reg_idxw_i(req_reg_idxw_i), .req_warpid_i(req_warpid_i),
    .tc_in_valid_o(tc_in_valid_o), .tc_in_ready_i(tc_in_ready_i),
    .tc_a_o(tc_a_o), .tc_b_o(tc_b_o), .tc_c_o(tc_c_o), .tc_rm_o(tc_rm_o),
    .tc_reg_idxw_o(tc_reg_idxw_o), .tc_warpid_o(tc_warpid_o),
    .tc_out_valid_i(tc_out_valid_i), .tc_out_ready_o(tc_out_ready_o),
    .tc_result_i(tc_result_i), .tc_fflags_i(tc_fflags_i),
    .tc_reg_idxw_i(tc_reg_idxw_i), .tc_warpid_i(tc_warpid_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_fflags_o(rsp_fflags_o),
    .rsp_reg_idxw_o(rsp_reg_idxw_o), .rsp_warpid_o(rsp_warpid_o),
    .inflight_o(inflight_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] vld;
    logic          rdy;
    logic          ov;
    logic [NR-1:0] e_rdy;
    logic          e_tcv;
    int            e_g;
    logic [NR-1:0] e_rsp;
    int            e_inf;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic [NR-1:0] vld, logic rdy, logic ov, logic [NR-1:0] e_rdy,
                              logic e_tcv, int e_g, logic [NR-1:0] e_rsp, int e_inf);
    vec_t v;
    v.vld = vld; v.rdy = rdy; v.ov = ov; v.e_rdy = e_rdy;
    v.e_tcv = e_tcv; v.e_g = e_g; v.e_rsp = e_rsp; v.e_inf = e_inf;
    return v;
  endfunction

  function automatic logic [OPW-1:0] pat(int r);
    logic [WW-1:0] w;
    w = 32'hA5A50000 | 32'(r);
    return {VL{w}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [NR-1:0] vld, input logic rdy, input logic ov);
    req_valid_i    = vld;
    tc_in_ready_i  = rdy;
    tc_out_valid_i = ov;
  endtask

  task automatic set_patterns();
    for (int r = 0; r < NR; r++) begin
      req_a_i[r*OPW +: OPW] = pat(r);
      req_b_i[r*OPW +: OPW] = ~pat(r);
    end
  endtask

  task automatic apply_reset();
    set_in('0, 1'b0, 1'b0);
    rsp_ready_i = '1;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Reference model: queue of outstanding requester ids, last-served pointer, held offer.
  int  mq[$];
  int  m_rr;
  bit  m_lk;
  int  m_lk_id;

  initial begin
    logic [NR-1:0] e_rdy, e_rsp;
    logic e_tcv, e_ordy, have, full;
    int g, hd, c;

    rst_n = 1'b0;
    req_a_i = '0; req_b_i = '0; req_c_i = '0; req_rm_i = '0;
    req_reg_idxw_i = '0; req_warpid_i = '0;
    tc_result_i = '0; tc_fflags_i = '0; tc_reg_idxw_i = '0; tc_warpid_i = '0;
    set_in('1, 1'b1, 1'b1);
    rsp_ready_i = '1;
    #3;
    chk("rst_req_ready", 256'(req_ready_o), 256'(0));
    chk("rst_tc_in_valid", 256'(tc_in_valid_o), 256'(0));
    chk("rst_rsp_valid", 256'(rsp_valid_o), 256'(0));
    chk("rst_tc_out_ready", 256'(tc_out_ready_o), 256'(0));
    chk("rst_inflight", 256'(inflight_o), 256'(0));
    chk("rst_err", 256'(err_o), 256'(0));

    // Table: issue, lock, fill to full, no-bypass at full, drain in issue order.
    tbl[0]  = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 0, 4'b0000, 0);
    tbl[1]  = mk(4'b0110, 1'b1, 1'b0, 4'b0010, 1'b1, 1, 4'b0000, 0);
    tbl[2]  = mk(4'b0110, 1'b1, 1'b0, 4'b0100, 1'b1, 2, 4'b0000, 1);
    tbl[3]  = mk(4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1, 0, 4'b0000, 2);
    tbl[4]  = mk(4'b1000, 1'b0, 1'b0, 4'b0000, 1'b1, 3, 4'b0000, 3);
    tbl[5]  = mk(4'b1001, 1'b0, 1'b0, 4'b0000, 1'b1, 3, 4'b0000, 3);
    tbl[6]  = mk(4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1, 3, 4'b0000, 3);
    tbl[7]  = mk(4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 0, 4'b0010, 4);
    tbl[8]  = mk(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 0, 4'b0000, 3);
    tbl[9]  = mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 0, 4'b0100, 4);
    tbl[10] = mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 0, 4'b0001, 3);
    tbl[11] = mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 0, 4'b1000, 2);
    tbl[12] = mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 0, 4'b0001, 1);
    tbl[13] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 0, 4'b0000, 0);

    set_patterns();
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i].vld, tbl[i].rdy, tbl[i].ov);
      @(negedge clk);
      chk($sformatf("tbl%0d_req_ready", i), 256'(req_ready_o), 256'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_tc_in_valid", i), 256'(tc_in_valid_o), 256'(tbl[i].e_tcv));
      chk($sformatf("tbl%0d_rsp_valid", i), 256'(rsp_valid_o), 256'(tbl[i].e_rsp));
      chk($sformatf("tbl%0d_inflight", i), 256'(inflight_o), 256'(tbl[i].e_inf));
      if (tbl[i].e_tcv) chk($sformatf("tbl%0d_tc_a", i), 256'(tc_a_o), 256'(pat(tbl[i].e_g)));
      step();
    end

    // Grant held on requester 2 through a stall even after requester 0 shows up.
    apply_reset();
    set_in(4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lock_tc_in_valid", 256'(tc_in_valid_o), 256'(1));
      chk("lock_tc_a", 256'(tc_a_o), 256'(pat(2)));
      step();
    end
    set_in(4'b0101, 1'b0, 1'b0);
    @(negedge clk);
    chk("lock_hold_tc_a", 256'(tc_a_o), 256'(pat(2)));
    step();
    set_in(4'b0101, 1'b1, 1'b0);
    @(negedge clk);
    chk("lock_fire_ready", 256'(req_ready_o), 256'(4'b0100));
    chk("lock_fire_tc_a", 256'(tc_a_o), 256'(pat(2)));
    step();
    set_in(4'b0001, 1'b1, 1'b0);
    @(negedge clk);
    chk("lock_wrap_ready", 256'(req_ready_o), 256'(4'b0001));
    step();
    // Locked requester 1 withdraws: error raised on the next cycle.
    set_in(4'b0010, 1'b0, 1'b0);
    step();
    set_in(4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("withdraw_err_pre", 256'(err_o), 256'(0));
    step();
    @(negedge clk);
    chk("withdraw_err", 256'(err_o), 256'(1));

    // Simultaneous issue and response at count 2.
    apply_reset();
    set_in(4'b0010, 1'b1, 1'b0);
    step();
    set_in(4'b0100, 1'b1, 1'b0);
    step();
    set_in(4'b0001, 1'b1, 1'b1);
    @(negedge clk);
    chk("pp_inflight_before", 256'(inflight_o), 256'(2));
    chk("pp_rsp_valid", 256'(rsp_valid_o), 256'(4'b0010));
    chk("pp_req_ready", 256'(req_ready_o), 256'(4'b0001));
    step();
    set_in(4'b0000, 1'b1, 1'b1);
    @(negedge clk);
    chk("pp_inflight_after", 256'(inflight_o), 256'(2));
    chk("pp_rsp_order1", 256'(rsp_valid_o), 256'(4'b0100));
    step();
    @(negedge clk);
    chk("pp_rsp_order2", 256'(rsp_valid_o), 256'(4'b0001));
    step();
    set_in(4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    chk("pp_drained", 256'(inflight_o), 256'(0));

    // Orphan response.
    apply_reset();
    set_in(4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    chk("orphan_out_ready", 256'(tc_out_ready_o), 256'(0));
    chk("orphan_rsp_valid", 256'(rsp_valid_o), 256'(0));
    chk("orphan_err_pre", 256'(err_o), 256'(0));
    step();
    set_in(4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("orphan_err", 256'(err_o), 256'(1));
    repeat (3) step();
    @(negedge clk);
    chk("orphan_err_sticky", 256'(err_o), 256'(1));

    // Reset with 3 operations in flight.
    apply_reset();
    set_in(4'b1111, 1'b1, 1'b0);
    repeat (3) step();
    set_in(4'b1111, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", 256'(req_ready_o), 256'(0));
    chk("mid_rst_tc_in_valid", 256'(tc_in_valid_o), 256'(0));
    chk("mid_rst_rsp_valid", 256'(rsp_valid_o), 256'(0));
    chk("mid_rst_tc_out_ready", 256'(tc_out_ready_o), 256'(0));
    chk("mid_rst_inflight", 256'(inflight_o), 256'(0));
    chk("mid_rst_err", 256'(err_o), 256'(0));
    tc_out_valid_i = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_inflight", 256'(inflight_o), 256'(0));
    chk("post_rst_grant0", 256'(req_ready_o), 256'(4'b0001));

    // Randomised traffic against the queue model.
    apply_reset();
    mq.delete();
    m_rr = 0;
    m_lk = 1'b0;
    m_lk_id = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid_i = NR'($urandom);
      if (m_lk) req_valid_i[m_lk_id] = 1'b1;
      tc_in_ready_i  = ($urandom_range(0, 3) != 0);
      tc_out_valid_i = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      rsp_ready_i    = NR'($urandom | $urandom);
      for (int k = 0; k < NR*VL; k++) begin
        req_a_i[k*WW +: WW] = $urandom;
        req_b_i[k*WW +: WW] = $urandom;
      end
      req_reg_idxw_i = $urandom;
      for (int k = 0; k < VL; k++) tc_result_i[k*WW +: WW] = $urandom;
      tc_reg_idxw_i = 8'($urandom);
      @(negedge clk);

      have = 1'b0;
      g = 0;
      if (m_lk) begin
        have = req_valid_i[m_lk_id];
        g = m_lk_id;
      end else begin
        for (int i = 0; i < NR; i++) begin
          c = (m_rr + i) % NR;
          if (!have && req_valid_i[c]) begin
            have = 1'b1;
            g = c;
          end
        end
      end
      full  = (mq.size() == MI);
      e_tcv = have && !full;
      e_rdy = (e_tcv && tc_in_ready_i) ? NR'(1 << g) : '0;
      hd    = (mq.size() > 0) ? mq[0] : 0;
      e_rsp = (tc_out_valid_i && mq.size() > 0) ? NR'(1 << hd) : '0;
      e_ordy = (mq.size() > 0) && rsp_ready_i[hd];

      chk("rnd_req_ready", 256'(req_ready_o), 256'(e_rdy));
      chk("rnd_tc_in_valid", 256'(tc_in_valid_o), 256'(e_tcv));
      chk("rnd_rsp_valid", 256'(rsp_valid_o), 256'(e_rsp));
      chk("rnd_tc_out_ready", 256'(tc_out_ready_o), 256'(e_ordy));
      chk("rnd_inflight", 256'(inflight_o), 256'(mq.size()));
      chk("rnd_err", 256'(err_o), 256'(0));
      chk("rnd_rsp_result", 256'(rsp_result_o), 256'(tc_result_i));
      chk("rnd_rsp_reg_idxw", 256'(rsp_reg_idxw_o), 256'(tc_reg_idxw_i));
      if (e_tcv) begin
        chk("rnd_tc_a", 256'(tc_a_o), 256'(req_a_i[g*OPW +: OPW]));
        chk("rnd_tc_b", 256'(tc_b_o), 256'(req_b_i[g*OPW +: OPW]));
        chk("rnd_tc_reg_idxw", 256'(tc_reg_idxw_o), 256'(req_reg_idxw_i[g*8 +: 8]));
      end

      if (tc_out_valid_i && e_ordy) void'(mq.pop_front());
      if (e_tcv && tc_in_ready_i) begin
        mq.push_back(g);
        m_rr = (g + 1) % NR;
        m_lk = 1'b0;
      end else if (e_tcv) begin
        m_lk = 1'b1;
        m_lk_id = g;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tensor_core_arbiter.md
# tensor_core_arbiter

Round-robin arbiter that shares one `tensor_core_fp32` instance among `NUM_REQ` issue requesters, for example per-warp-group issue slots.
- Grants one request per accepted transfer and holds the grant stable while the core stalls.
- Caps outstanding operations with an in-order ID FIFO.
- Routes each core result back to the requester that issued it.

The block sits between the SM issue stage and the tensor core; the core is in-order, so responses return in issue order.

## Interface
- `NUM_REQ`, 4: number of requesters; must be a power of two, ≥2.
- `VL`, `` `NUM_THREAD ``: lanes per operand.
- `WORD_W`, 32: element width (EXPWIDTH+PRECISION).
- `MAX_INFLIGHT`, 4: ID FIFO depth and maximum outstanding operations; must be a power of two.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid_i` in NUM_REQ: per-requester valid.
- `req_ready_o` out NUM_REQ: per-requester ready.
- `req_a_i` / `req_b_i` / `req_c_i` in NUM_REQ*VL*WORD_W each: operands, packed with requester r at slice r.
- `req_rm_i` in NUM_REQ*VL*3: rounding modes.
- `req_reg_idxw_i` in NUM_REQ*8: destination register index.
- `req_warpid_i` in NUM_REQ*`DEPTH_WARP`: warp id.
- `tc_in_valid_o` out 1, `tc_in_ready_i` in 1: core input handshake.
- `tc_a_o` / `tc_b_o` / `tc_c_o` out VL*WORD_W; `tc_rm_o` out VL*3; `tc_reg_idxw_o` out 8; `tc_warpid_o` out `DEPTH_WARP`: muxed operands for the granted requester.
- `tc_out_valid_i` in 1, `tc_out_ready_o` out 1: core output handshake.
- `tc_result_i` in VL*WORD_W; `tc_fflags_i` in VL*5; `tc_reg_idxw_i` in 8; `tc_warpid_i` in `DEPTH_WARP`: core result.
- `rsp_valid_o` out NUM_REQ, `rsp_ready_i` in NUM_REQ: per-requester response handshake.
- `rsp_result_o`, `rsp_fflags_o`, `rsp_reg_idxw_o`, `rsp_warpid_o` out: shared response bus; straight pass-through of the `tc_*_i` result fields.
- `inflight_o` out $clog2(MAX_INFLIGHT)+1: outstanding count.
- `err_o` out 1: sticky protocol error.

## Operation
- **Registered state:**
  - `rr_ptr` (log2 NUM_REQ bits), the round-robin start point.
  - `lock_vld` / `lock_id`, the held grant.
  - The ID FIFO: `MAX_INFLIGHT` entries of log2 NUM_REQ bits, with read/write pointers and a count.
  - `err`.
- **Grant selection (combinational):**
  - If `lock_vld`, the grant is `g = lock_id`.
  - Otherwise `g` is the first r with `req_valid_i[r]`, searching from `rr_ptr` upward modulo NUM_REQ.
- **Issue:**
  - `tc_in_valid_o = grant_exists & (count < MAX_INFLIGHT)`.
  - The `tc_*_o` operands are requester g's slices.
  - `req_ready_o[g] = tc_in_ready_i & (count < MAX_INFLIGHT)`; every other bit is 0.
- **Issue fire** (`tc_in_valid_o & tc_in_ready_i`):
  - Push g to the FIFO.
  - `rr_ptr <= g+1` (wraps).
  - `lock_vld <= 0`.
- **Grant lock:** if `tc_in_valid_o & !tc_in_ready_i`, then `lock_vld <= 1` and `lock_id <= g`. The grant never changes before fire, even if a higher-priority request arrives.
- **Full FIFO:** when `count == MAX_INFLIGHT`, `tc_in_valid_o` and every `req_ready_o` bit are 0, and the lock is kept.
- **Response routing:**
  - head = FIFO head ID.
  - `rsp_valid_o[head] = tc_out_valid_i & (count != 0)`; all other bits are 0.
  - `tc_out_ready_o = rsp_ready_i[head] & (count != 0)`.
  - On response fire, pop the head.
- **Simultaneous push and pop:** count is unchanged and both pointers advance. A pop frees space only on the next cycle, so there is no same-cycle bypass at full.
- **Orphan response:** `tc_out_valid_i` while `count == 0` sets `err` (sticky until reset). `tc_out_ready_o` stays 0 in that case.
- **Unlocked withdrawal:** a requester may drop valid while its request is unlocked. A requester must not drop valid while locked; doing so sets `err`.
- **Counter width:** count saturates structurally at `MAX_INFLIGHT`; pointers wrap modulo depth.

## Timing
- **Reset:** asynchronous reset clears `rr_ptr`, `lock_vld`, `lock_id`, the FIFO pointers, count and `err` to 0.
- **Outputs during reset:**
  - `req_ready_o`, `rsp_valid_o`, `tc_in_valid_o`, `tc_out_ready_o` = 0.
  - `inflight_o` = 0.
  - `err_o` = 0.
- **Latency:** request to `tc_in_valid_o` and core result to `rsp_valid_o` are both combinational (zero added cycles). Grant, lock and FIFO updates take effect the next cycle.
- **Throughput:** one issue and one response per cycle.
- **Reset mid-operation:** all tracking is discarded. Results the core returns after reset count as orphans.

## Test plan
- Requesters 0–3 all valid, `tc_in_ready_i` tied 1, core returns each result 3 cycles later → grant order is 0,1,2,3,0,…; each response is routed to the issuing requester.
- Requester 2 valid with `tc_in_ready_i` = 0 for 5 cycles, then requester 0 raises valid → `tc_a_o` stays on requester 2 and `req_ready_o` = 0100 on the fire cycle. The next grant is 3 if valid, otherwise wraps to 0.
- `MAX_INFLIGHT` = 4, no responses returned → 4 issues, then `tc_in_valid_o` = 0 and `inflight_o` = 4. Returning one response re-enables issue the next cycle.
- At count = 2, issue fire and response fire in the same cycle → count stays 2 and FIFO order is preserved.
- `tc_out_valid_i` = 1 with count = 0 → `err_o` = 1 the next cycle and stays 1 until reset; `tc_out_ready_o` = 0.
- Assert `rst_n` low with 3 operations in flight → all outputs 0 immediately; after release, `inflight_o` = 0 and arbitration restarts at requester 0.
